// File: rtl/addertree_accum_pipe.sv
// addertree_accum_pipe: pipelined signed adder tree feeding a framed accumulator.
// Each accepted beat sums NUM_IN signed products through an input register and
// L = ceil(log2(NUM_IN)) registered tree levels. The tree sum is then added into a
// running accumulator over a frame delimited by first/last. A last beat loads the
// output register.
// Optional feature macro: ADDERTREE_SAT_EN. When it is defined, the accumulator
// saturates on overflow. Otherwise the accumulator wraps modulo 2^ACC_W.
//
// Handshake (both sides use strict valid/ready): a beat or result transfers on a
// rising edge where valid && ready. The in_ready output is combinational from
// out_valid/out_ready only. A pending result that is not taken stalls the whole
// pipeline.
module addertree_accum_pipe #(
  parameter int NUM_IN = 9,
  parameter int IN_W   = 16,
  parameter int ACC_W  = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_ovf
);

  localparam int L      = (NUM_IN > 1) ? $clog2(NUM_IN) : 0;
  localparam int TREE_W = IN_W + L;
  // The tree is padded to a power of two with zero leaves. Adding a zero leaf is
  // the same as passing an odd leftover element through, sign-extended.
  localparam int P      = 1 << L;

  // node_q[0] is the registered input. node_q[k] holds level k, and element 0 of
  // level L is the tree sum.
  logic signed [TREE_W-1:0] node_q [L+1][P];
  logic [L:0]               vld_q;
  logic [L:0]               first_q;
  logic [L:0]               last_q;

  logic signed [ACC_W-1:0]  acc_q;
  logic                     ovf_q;
  logic signed [ACC_W-1:0]  tree_sum;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic                     step_ovf;
  logic                     ovf_nxt;

  assign in_ready = !(out_valid && !out_ready);

  // Input register and tree levels: everything advances together and holds on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (in_ready) begin
      vld_q[0]   <= in_valid;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      for (int j = 0; j < NUM_IN; j++)
        node_q[0][j] <= TREE_W'(signed'(in_data[j*IN_W +: IN_W]));
      for (int j = NUM_IN; j < P; j++)
        node_q[0][j] <= '0;
      for (int k = 1; k <= L; k++) begin
        vld_q[k]   <= vld_q[k-1];
        first_q[k] <= first_q[k-1];
        last_q[k]  <= last_q[k-1];
        for (int j = 0; j < (P >> k); j++)
          node_q[k][j] <= node_q[k-1][2*j] + node_q[k-1][2*j+1];
        for (int j = (P >> k); j < P; j++)
          node_q[k][j] <= '0;
      end
    end
  end

  // Accumulate step: a first beat starts from zero, so it can never overflow and
  // it drops the sticky flag from the previous frame.
  always_comb begin
    tree_sum = ACC_W'(node_q[L][0]);
    base     = first_q[L] ? '0 : acc_q;
    sum      = base + tree_sum;
    step_ovf = (base[ACC_W-1] == tree_sum[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    ovf_nxt  = step_ovf | (ovf_q & ~first_q[L]);
`ifdef ADDERTREE_SAT_EN
    if (ovf_q && !first_q[L])
      acc_nxt = acc_q;
    else if (step_ovf)
      acc_nxt = tree_sum[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_nxt = sum;
`else
    acc_nxt = sum;
`endif
  end

  // Accumulator and output register: a last beat loads a result, a taken result clears valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (in_ready) begin
      if (vld_q[L]) begin
        acc_q <= acc_nxt;
        ovf_q <= ovf_nxt;
      end
      if (vld_q[L] && last_q[L]) begin
        out_valid <= 1'b1;
        out_data  <= acc_nxt;
        out_ovf   <= ovf_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addertree_accum_pipe.sv
// Bench for addertree_accum_pipe (NUM_IN=9, IN_W=16, ACC_W=20) using directed
// scenarios followed by randomized frames. Expected results come from an integer
// frame-sum model. The optional macro ADDERTREE_SAT_EN switches the model to
// saturation as well.
module tb_addertree_accum_pipe;

  localparam int NUM_IN = 9;
  localparam int IN_W   = 16;
  localparam int ACC_W  = 20;
  localparam int DW     = NUM_IN * IN_W;
  localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W - 1));
  localparam longint SPAN = longint'(1) << ACC_W;
`ifdef ADDERTREE_SAT_EN
  localparam logic [ACC_W-1:0] OVF_EXP = 20'h7FFFF;
`else
  localparam logic [ACC_W-1:0] OVF_EXP = 20'hD7FE5;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  int n_checks = 0;
  int n_errors = 0;
  logic [ACC_W:0] exp_q[$];   // {ovf, data}
  longint m_acc = 0;
  logic   m_ovf = 1'b0;
  logic   rand_ready = 1'b0;
  logic [ACC_W:0] mon_e;

  addertree_accum_pipe #(.NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [IN_W-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < NUM_IN; i++) r[i*IN_W +: IN_W] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < NUM_IN; i++) begin
      case ($urandom_range(0, 5))
        0:       r[i*IN_W +: IN_W] = 16'h7FFF;
        1:       r[i*IN_W +: IN_W] = 16'h8000;
        default: r[i*IN_W +: IN_W] = IN_W'($urandom_range(0, 65535));
      endcase
    end
    return r;
  endfunction

  function automatic longint beat_sum(input logic [DW-1:0] d);
    longint s = 0;
    logic signed [IN_W-1:0] p;
    for (int i = 0; i < NUM_IN; i++) begin
      p = d[i*IN_W +: IN_W];
      s += p;
    end
    return s;
  endfunction

  // Reference model: the exact frame sum in 64-bit arithmetic, reduced to ACC_W
  task automatic model_accept(input logic [DW-1:0] d, input logic f, input logic l);
    longint t;
    logic [ACC_W:0] e;
    if (f) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    t = m_acc + beat_sum(d);
`ifdef ADDERTREE_SAT_EN
    if (!m_ovf) begin
      if (t > MAXV) begin m_acc = MAXV; m_ovf = 1'b1; end
      else if (t < MINV) begin m_acc = MINV; m_ovf = 1'b1; end
      else m_acc = t;
    end
`else
    if (t > MAXV || t < MINV) m_ovf = 1'b1;
    while (t > MAXV) t -= SPAN;
    while (t < MINV) t += SPAN;
    m_acc = t;
`endif
    if (l) begin
      e[ACC_W-1:0] = m_acc[ACC_W-1:0];
      e[ACC_W]     = m_ovf;
      exp_q.push_back(e);
    end
  endtask

  // Driver: called and returning at posedge+1
  task automatic send_beat(input logic [DW-1:0] d, input logic f, input logic l);
    int w = 0;
    in_data = d; in_first = f; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin w++; @(negedge clk); end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else model_accept(d, f, l);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 400) begin w++; @(negedge clk); end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic collect(input int cyc, output int n, output logic [ACC_W-1:0] d0,
                         output logic [ACC_W-1:0] d1, output logic o0);
    n = 0; d0 = '0; d1 = '0; o0 = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (n == 0) begin d0 = out_data; o0 = out_ovf; end
        else if (n == 1) d1 = out_data;
        n++;
      end
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard: every result taken downstream must match the model queue front
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", out_valid, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("result_data", out_data, mon_e[ACC_W-1:0]);
        chk("result_ovf", out_ovf, mon_e[ACC_W]);
      end
    end
  end

  // Random downstream readiness while enabled
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int n;
    logic [ACC_W-1:0] d0, d1, held;
    logic o0;
    int w;
    logic [ACC_W-1:0] neg27;
    neg27 = -27;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Non-first beat straight after reset accumulates onto zero
    send_beat(fill(16'd2), 1'b0, 1'b1);
    collect(10, n, d0, d1, o0);
    chk("nofirst_count", n, 1);
    chk("nofirst_data", d0, 18);
    wait_drain();

    // Single beat of 3s: result exactly 5 cycles after the accepting edge
    send_beat(fill(16'd3), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lat_idle", out_valid, 0);
    end
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 27);
    chk("lat_ovf", out_ovf, 0);
    @(posedge clk); #1;
    wait_drain();

    // Three beats of -1: one pulse of -27
    send_beat(fill(16'hFFFF), 1'b1, 1'b0);
    send_beat(fill(16'hFFFF), 1'b0, 1'b0);
    send_beat(fill(16'hFFFF), 1'b0, 1'b1);
    collect(10, n, d0, d1, o0);
    chk("neg_count", n, 1);
    chk("neg_data", d0, neg27);
    wait_drain();

    // Back-to-back frames A (1s, one beat) and B (2s, two beats)
    send_beat(fill(16'd1), 1'b1, 1'b1);
    send_beat(fill(16'd2), 1'b1, 1'b0);
    send_beat(fill(16'd2), 1'b0, 1'b1);
    collect(14, n, d0, d1, o0);
    chk("b2b_count", n, 2);
    chk("b2b_a", d0, 9);
    chk("b2b_b", d1, 36);
    wait_drain();

    // Backpressure: hold a result for 4 cycles, then drain in order
    out_ready = 1'b0;
    send_beat(fill(16'd1), 1'b1, 1'b1);
    send_beat(fill(16'd2), 1'b1, 1'b1);
    send_beat(fill(16'd3), 1'b1, 1'b1);
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 50) begin w++; @(negedge clk); end
    chk("bp_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    held = out_data;
    chk("bp_first_data", held, 9);
    in_data = fill(16'd4); in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    model_accept(fill(16'd4), 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // Overflow: three beats of 0x7FFF in a 20-bit accumulator
    send_beat(fill(16'h7FFF), 1'b1, 1'b0);
    send_beat(fill(16'h7FFF), 1'b0, 1'b0);
    send_beat(fill(16'h7FFF), 1'b0, 1'b1);
    collect(10, n, d0, d1, o0);
    chk("ovf_count", n, 1);
    chk("ovf_data", d0, OVF_EXP);
    chk("ovf_flag", o0, 1);
    // A first beat clears the sticky flag
    send_beat(fill(16'd1), 1'b1, 1'b1);
    collect(10, n, d0, d1, o0);
    chk("ovf_clear_data", d0, 9);
    chk("ovf_clear_flag", o0, 0);
    wait_drain();

    // Reset mid-frame after two beats, then a single-beat frame
    send_beat(fill(16'd1), 1'b1, 1'b0);
    send_beat(fill(16'd1), 1'b0, 1'b0);
    reset = 1'b1;
    m_acc = 0; m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_ovf", out_ovf, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    send_beat(fill(16'd1), 1'b1, 1'b1);
    collect(12, n, d0, d1, o0);
    chk("midrst_count", n, 1);
    chk("midrst_data", d0, 9);
    wait_drain();

    // In-flight beats and partial sum must not leak past a reset
    send_beat(fill(16'd3), 1'b1, 1'b0);
    send_beat(fill(16'd3), 1'b0, 1'b0);
    reset = 1'b1;
    m_acc = 0; m_ovf = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    send_beat(fill(16'd1), 1'b0, 1'b1);
    collect(12, n, d0, d1, o0);
    chk("rst_flush_count", n, 1);
    chk("rst_flush_data", d0, 9);
    wait_drain();

    // Randomized frames with gaps and random downstream readiness
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      logic start;
      len = $urandom_range(1, 4);
      start = ($urandom_range(0, 7) != 0);
      for (int b = 0; b < len; b++) begin
        int g;
        send_beat(rand_data(), (b == 0) && start, b == len - 1);
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addertree_accum_pipe.md
# addertree_accum_pipe

Parametrised, pipelined signed adder tree with a built-in multi-beat accumulator, the next generation of the NPU's fixed-width partial-sum reduction stages. Each accepted beat sums NUM_IN signed products. The sum is added into a running accumulator over a frame delimited by first/last flags, replacing the external pre-output feedback path. The block sits between the multiplier array and the activation/writeback stage, with a valid/ready handshake on both sides.

## Interface
- NUM_IN, default 9: number of product inputs per beat, ≥1.
- IN_W, default 16: width of each signed product.
- ACC_W, default 24: accumulator and output width. Must satisfy ACC_W ≥ IN_W + L.
- L (derived): ceil(log2(NUM_IN)), the number of tree levels. L = 0 when NUM_IN = 1.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- in_valid, input, 1: beat present.
- in_ready, output, 1: beat accepted when in_valid && in_ready.
- in_data, input, NUM_IN*IN_W: product i is at bits [i*IN_W +: IN_W], two's complement.
- in_first, input, 1: beat starts a new accumulation frame.
- in_last, input, 1: beat ends the frame and produces a result.
- out_valid, output, 1: result held in out_data.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, ACC_W: signed frame sum.
- out_ovf, output, 1: the frame overflowed ACC_W at any accumulation step.

## Operation
- Tree: at each level, adjacent pairs are added and the result is sign-extended by 1 bit. An odd leftover element passes through, sign-extended. Each level is registered. The tree result is IN_W+L bits and is sign-extended to ACC_W.
- Flags first/last travel with the data in per-level valid/first/last registers.
- Accumulate stage, on a tree-output beat:
  - If first: acc = tree_sum.
  - Otherwise: acc = acc + tree_sum.
  - Overflow is detected with the signed rule: operands have the same sign and the result sign differs. The sticky ovf bit is set on overflow and cleared by a first beat (which takes the overflow of that beat alone).
- On a beat with last:
  - out_data ← the new acc value.
  - out_ovf ← the sticky ovf including this beat.
  - out_valid ← 1.
- A beat with both first and last is a single-beat frame.
- A beat without first after reset accumulates onto acc = 0.
- Gaps are allowed: in_valid may be low mid-frame, and the accumulator holds its value.
- Output register: out_valid clears on out_valid && out_ready unless a new result loads in the same cycle, in which case it stays 1 with the new data.
- Stall: in_ready = !(out_valid && !out_ready). While in_ready = 0:
  - every pipeline register, the accumulator and the output register hold;
  - no beat is accepted.
- Reset values:
  - in_ready = 1.
  - out_valid = 0, out_data = 0, out_ovf = 0.
  - All pipeline valids = 0, acc = 0, sticky ovf = 0.
- Reset mid-frame discards all in-flight beats and the partial sum. No result is emitted.

## Timing
- Throughput: 1 beat/cycle when there is no stall.
- Latency: out_valid rises L+1 cycles after the accepting edge of a last beat. For the defaults (NUM_IN=9, L=4), latency is 5 cycles. For NUM_IN=1, latency is 1 cycle.
- Back-to-back frames: a last beat followed immediately by a first beat is legal, and the results appear on consecutive cycles.
- in_ready is combinational from out_valid and out_ready only. It never depends on in_valid.
- reset has priority over all other activity in the same cycle.

## Configuration
- ADDERTREE_SAT_EN defined:
  - On overflow, the accumulate stage clamps acc to +2^(ACC_W-1)-1 or -2^(ACC_W-1), following the sign of the operands. The accumulator stays clamped until the next first beat.
  - out_ovf still reports the overflow.
- ADDERTREE_SAT_EN undefined:
  - acc wraps modulo 2^ACC_W.
  - out_ovf reports the wrap.

## Test plan
- Single beat, NUM_IN=9, all inputs 0x0003, first=last=1 -> out_data=27 exactly 5 cycles later, out_ovf=0.
- Three-beat frame with all inputs = -1 (0xFFFF) on every beat -> out_data = -27 (ACC_W two's complement), one out_valid pulse.
- Back-to-back frames: frame A (all inputs 1, one beat) then frame B (all inputs 2, two beats) -> results 9 and 36 on successive out_valid pulses, no cross-contamination.
- Backpressure: hold out_ready=0 for 4 cycles while a result is valid -> in_ready=0, out_data stable; release -> pending beats drain in order with no loss or duplication.
- Overflow with ACC_W=20: accumulate all inputs = 0x7FFF for 3 beats -> out_ovf=1. Without the macro, out_data is the wrapped value mod 2^20. With ADDERTREE_SAT_EN, out_data = 0x7FFFF.
- Assert reset for 1 cycle mid-frame after two beats, then send first=last beat of all 1s -> only out_data=9 appears, and all outputs read 0 during reset.
